// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file access bus: write port 3 and read ports 1/2
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (output we3, ra1, ra2, wa3, wd3, input rd1, rd2);
  modport slave  (input we3, ra1, ra2, wa3, wd3, output rd1, rd2);
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**ADDR_W x DATA_W register file, two combinational reads, one clocked write
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:NREGS-1];

  // Writes to register 0 are dropped so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we3 && (bus.wa3 != '0)) begin
      regs[bus.wa3] <= bus.wd3;
    end
  end

  // No write-to-read bypass: a same-address read sees the new value only after the edge.
  always_comb begin
    bus.rd1 = (bus.ra1 == '0) ? '0 : regs[bus.ra1];
    bus.rd2 = (bus.ra2 == '0) ? '0 : regs[bus.ra2];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bif ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
    bif.we3 = 1'b1;
    bif.wa3 = addr;
    bif.wd3 = data;
    tick();
    bif.we3 = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    bif.we3    = 1'b0;
    bif.ra1    = '0;
    bif.ra2    = '0;
    bif.wa3    = '0;
    bif.wd3    = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    bif.ra1 = 5'd5;
    bif.ra2 = 5'd31;
    #1;
    check("reset_state_rd1", bif.rd1, 32'h0);
    check("reset_state_rd2", bif.rd2, 32'h0);

    // Async reset between edges
    doWrite(5'd5, 32'hA5A5_0005);
    doWrite(5'd31, 32'h3131_3131);
    check("pre_reset_rd1", bif.rd1, 32'hA5A5_0005);
    check("pre_reset_rd2", bif.rd2, 32'h3131_3131);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_rd1", bif.rd1, 32'h0);
    check("async_reset_rd2", bif.rd2, 32'h0);
    tick();
    reset = 1'b0;
    #1;

    // Basic write/read
    doWrite(5'd2, 32'd12);
    bif.ra1 = 5'd2;
    bif.ra2 = 5'd3;
    #1;
    check("basic_rd1_reg2", bif.rd1, 32'd12);
    check("basic_rd2_reg3", bif.rd2, 32'd0);

    // Write disabled
    bif.we3 = 1'b0;
    bif.wa3 = 5'd3;
    bif.wd3 = 32'hDEAD_BEEF;
    tick();
    tick();
    bif.ra2 = 5'd3;
    bif.ra1 = 5'd2;
    #1;
    check("we_off_rd2_reg3", bif.rd2, 32'd0);
    check("we_off_rd1_reg2", bif.rd1, 32'd12);

    // Register 0 immutable
    doWrite(5'd0, 32'hFFFF_FFFF);
    bif.ra1 = 5'd0;
    bif.ra2 = 5'd0;
    #1;
    check("reg0_rd1", bif.rd1, 32'h0);
    check("reg0_rd2", bif.rd2, 32'h0);

    // Same-address read during write
    doWrite(5'd4, 32'h11);
    bif.ra1 = 5'd4;
    bif.ra2 = 5'd4;
    bif.we3 = 1'b1;
    bif.wa3 = 5'd4;
    bif.wd3 = 32'h22;
    #1;
    check("raw_before_rd1", bif.rd1, 32'h11);
    check("raw_before_rd2", bif.rd2, 32'h11);
    tick();
    bif.we3 = 1'b0;
    check("raw_after_rd1", bif.rd1, 32'h22);
    check("raw_after_rd2", bif.rd2, 32'h22);

    // Sweep regs 1..31 with i*3, read back in crossed pairs
    for (int i = 1; i < 32; i++) begin
      doWrite(5'(i), 32'(i * 3));
    end
    for (int i = 1; i < 32; i++) begin
      bif.ra1 = 5'(i);
      bif.ra2 = 5'(32 - i);
      #1;
      check($sformatf("sweep_rd1_r%0d", i), bif.rd1, 32'(i * 3));
      check($sformatf("sweep_rd2_r%0d", 32 - i), bif.rd2, 32'((32 - i) * 3));
    end

    // Mid-op reset with a pending write to reg 7
    bif.we3 = 1'b1;
    bif.wa3 = 5'd7;
    bif.wd3 = 32'h0000_0777;
    bif.ra1 = 5'd7;
    bif.ra2 = 5'd9;
    #2;
    reset = 1'b1;
    #1;
    check("midop_reset_rd1", bif.rd1, 32'h0);
    check("midop_reset_rd2", bif.rd2, 32'h0);
    tick();
    check("write_under_reset_rd1", bif.rd1, 32'h0);
    reset   = 1'b0;
    bif.we3 = 1'b0;
    #1;
    check("post_reset_reg7", bif.rd1, 32'h0);
    bif.ra1 = 5'd31;
    bif.ra2 = 5'd1;
    #1;
    check("post_reset_reg31", bif.rd1, 32'h0);
    check("post_reset_reg1", bif.rd2, 32'h0);

    // Storage still writable after reset
    doWrite(5'd7, 32'h0000_0777);
    bif.ra1 = 5'd7;
    #1;
    check("post_reset_write_reg7", bif.rd1, 32'h0000_0777);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
